// File: rtl/lod_norm_pipe.sv
// Leading-one / leading-zero / regime-run detector with left normalisation,
// carried through a valid/ready pipeline of STAGES register slots.
module lod_norm_pipe #(
    parameter int unsigned N      = 64,
    parameter int unsigned STAGES = 2,
    localparam int unsigned S     = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [S-1:0] out_pos,
    output logic         out_found,
    output logic [N-1:0] out_norm
);

    logic [N-1:0] det_c;
    logic [S-1:0] pos_c;
    logic         found_c;
    logic [N-1:0] norm_c;

    logic         live;
    logic         acc [STAGES];
    logic         stg_vld   [STAGES];
    logic [S-1:0] stg_pos   [STAGES];
    logic         stg_found [STAGES];
    logic [N-1:0] stg_norm  [STAGES];

    // Map every mode onto a leading-one search; LSB-side padding is implicitly
    // zero after the mapping, so it can never be picked as a target.
    always_comb begin
        det_c   = in_data;
        pos_c   = '0;
        found_c = 1'b0;
        case (in_mode)
            2'b01:   det_c = ~in_data;
            2'b10:   det_c = in_data ^ {N{in_data[N-1]}};
            default: det_c = in_data;
        endcase
        for (int i = 0; i < int'(N); i++) begin
            if (!found_c && det_c[N-1-i]) begin
                found_c = 1'b1;
                pos_c   = S'(i);
            end
        end
        norm_c = found_c ? (in_data << pos_c) : '0;
    end

    // A slot can take a new beat when it is empty or its contents move on.
    always_comb begin
        logic nxt;
        nxt = out_ready;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            nxt    = !stg_vld[i] || nxt;
            acc[i] = nxt;
        end
    end

    assign in_ready = live && acc[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live <= 1'b0;
            for (int i = 0; i < int'(STAGES); i++) begin
                stg_vld[i]   <= 1'b0;
                stg_pos[i]   <= '0;
                stg_found[i] <= 1'b0;
                stg_norm[i]  <= '0;
            end
        end else begin
            live <= 1'b1;
            if (acc[0]) begin
                stg_vld[0] <= in_valid && live;
                if (in_valid && live) begin
                    stg_pos[0]   <= pos_c;
                    stg_found[0] <= found_c;
                    stg_norm[0]  <= norm_c;
                end
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (acc[i]) begin
                    stg_vld[i] <= stg_vld[i-1];
                    if (stg_vld[i-1]) begin
                        stg_pos[i]   <= stg_pos[i-1];
                        stg_found[i] <= stg_found[i-1];
                        stg_norm[i]  <= stg_norm[i-1];
                    end
                end
            end
        end
    end

    assign out_valid = stg_vld[STAGES-1];
    assign out_pos   = stg_pos[STAGES-1];
    assign out_found = stg_found[STAGES-1];
    assign out_norm  = stg_norm[STAGES-1];

endmodule

// File: tb/tb_lod_norm_pipe.sv
// Randomised scoreboard bench for lod_norm_pipe: an N=8/STAGES=2 instance with
// back-pressure and an N=5/STAGES=3 instance with a free-running sink.
module tb_lod_norm_pipe;

    localparam int unsigned ST8 = 2;
    localparam int unsigned ST5 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, out_valid, out_ready, out_found;
    logic [7:0] in_data, out_norm;
    logic [1:0] in_mode;
    logic [2:0] out_pos;

    logic       v5, r5, ov5, f5;
    logic       or5 = 1'b1;
    logic [4:0] d5, n5;
    logic [1:0] m5;
    logic [2:0] p5;

    lod_norm_pipe #(.N(8), .STAGES(ST8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_pos(out_pos), .out_found(out_found),
        .out_norm(out_norm));

    lod_norm_pipe #(.N(5), .STAGES(ST5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(v5), .in_ready(r5),
        .in_data(d5), .in_mode(m5), .out_valid(ov5),
        .out_ready(or5), .out_pos(p5), .out_found(f5),
        .out_norm(n5));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          pos;
        bit          fnd;
        logic [63:0] norm;
    } exp_t;

    exp_t q8[$];
    exp_t q5[$];

    // Count the leading bits equal to the "skip" value; the first other bit is the target.
    function automatic exp_t ref_model(input int w, input logic [63:0] d, input logic [1:0] m);
        exp_t e;
        logic skip;
        int   run;
        skip = (m == 2'b01) ? 1'b1 : (m == 2'b10) ? d[w-1] : 1'b0;
        run = 0;
        while (run < w && d[w-1-run] == skip) run++;
        if (run == w) begin
            e.pos = 0; e.fnd = 1'b0; e.norm = '0;
        end else begin
            e.pos = run; e.fnd = 1'b1; e.norm = (d << run) & ((64'd1 << w) - 64'd1);
        end
        return e;
    endfunction

    function automatic logic [63:0] rdat(input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom % 4)
            0:       return '0;
            1:       return mask;
            2:       return ({$urandom, $urandom} & mask) >> ($urandom % w);
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    // Scoreboard and hold-stability monitor for the 8-bit instance.
    exp_t       e8;
    bit         hold8 = 1'b0;
    logic [2:0] hp;
    logic       hf;
    logic [7:0] hn;
    always @(negedge clk) begin
        if (rst) begin
            hold8 = 1'b0;
        end else begin
            if (hold8 && out_valid) begin
                check("hold_pos", 64'(out_pos), 64'(hp));
                check("hold_found", 64'(out_found), 64'(hf));
                check("hold_norm", 64'(out_norm), 64'(hn));
            end
            if (out_valid && out_ready) begin
                if (q8.size() == 0) check("spurious8", 64'(out_valid), 64'(0));
                else begin
                    e8 = q8.pop_front();
                    check("pos8", 64'(out_pos), 64'(e8.pos));
                    check("found8", 64'(out_found), 64'(e8.fnd));
                    check("norm8", 64'(out_norm), e8.norm);
                end
            end
            if (in_valid && in_ready) q8.push_back(ref_model(8, 64'(in_data), in_mode));
            hold8 = out_valid && !out_ready;
            hp = out_pos; hf = out_found; hn = out_norm;
        end
    end

    exp_t e5;
    always @(negedge clk) begin
        if (!rst) begin
            if (ov5 && or5) begin
                if (q5.size() == 0) check("spurious5", 64'(ov5), 64'(0));
                else begin
                    e5 = q5.pop_front();
                    check("pos5", 64'(p5), 64'(e5.pos));
                    check("found5", 64'(f5), 64'(e5.fnd));
                    check("norm5", 64'(n5), e5.norm);
                end
            end
            if (v5 && r5) q5.push_back(ref_model(5, 64'(d5), m5));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dir8(input string tag, input logic [7:0] d, input logic [1:0] m,
                        input logic [2:0] ep, input logic ef, input logic [7:0] en);
        int lat;
        out_ready = 1'b1; in_data = d; in_mode = m; in_valid = 1'b1;
        @(negedge clk);
        check({tag, "_rdy"}, 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_mode = ~m; in_data = ~d;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(ST8));
        check({tag, "_pos"}, 64'(out_pos), 64'(ep));
        check({tag, "_found"}, 64'(out_found), 64'(ef));
        check({tag, "_norm"}, 64'(out_norm), 64'(en));
    endtask

    task automatic dir5(input string tag, input logic [4:0] d, input logic [1:0] m,
                        input logic [2:0] ep, input logic ef, input logic [4:0] en);
        int lat;
        d5 = d; m5 = m; v5 = 1'b1;
        @(negedge clk);
        check({tag, "_rdy"}, 64'(r5), 64'(1));
        @(posedge clk);
        #1;
        v5 = 1'b0;
        lat = 1;
        while (!ov5 && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(ST5));
        check({tag, "_pos"}, 64'(p5), 64'(ep));
        check({tag, "_found"}, 64'(f5), 64'(ef));
        check({tag, "_norm"}, 64'(n5), 64'(en));
    endtask

    initial begin
        int         acc_cnt;
        int         guard;
        logic [7:0] bp_d [4];
        logic [1:0] bp_m [4];

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0;
        v5 = 1'b0; d5 = '0; m5 = '0;
        repeat (2) tick();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_pos", 64'(out_pos), 64'(0));
        check("rst_found", 64'(out_found), 64'(0));
        check("rst_norm", 64'(out_norm), 64'(0));
        check("rst_in_ready5", 64'(r5), 64'(0));
        rst = 1'b0;
        #1;
        check("rdy_before_edge", 64'(in_ready), 64'(0));
        tick();
        check("rdy_after_edge", 64'(in_ready), 64'(1));

        dir8("lo",     8'b0001_0110, 2'b00, 3'd3, 1'b1, 8'b1011_0000);
        dir8("lz",     8'b1110_1111, 2'b01, 3'd3, 1'b1, 8'b0111_1000);
        dir8("rg",     8'b1110_0101, 2'b10, 3'd3, 1'b1, 8'b0010_1000);
        dir8("zero",   8'b0000_0000, 2'b00, 3'd0, 1'b0, 8'b0000_0000);
        dir8("rgones", 8'b1111_1111, 2'b10, 3'd0, 1'b0, 8'b0000_0000);
        dir8("m11",    8'b0001_0110, 2'b11, 3'd3, 1'b1, 8'b1011_0000);
        dir8("msb",    8'b1000_0001, 2'b00, 3'd0, 1'b1, 8'b1000_0001);
        dir8("lsb",    8'b0000_0001, 2'b00, 3'd7, 1'b1, 8'b1000_0000);
        dir5("n5lo",   5'b00100, 2'b00, 3'd2, 1'b1, 5'b10000);
        dir5("n5lz",   5'b11111, 2'b01, 3'd0, 1'b0, 5'b00000);
        dir5("n5rg",   5'b00001, 2'b10, 3'd4, 1'b1, 5'b10000);

        // Back-pressure: four offered beats, sink stalled for four cycles.
        for (int k = 0; k < 4; k++) begin
            bp_d[k] = 8'(rdat(8));
            bp_m[k] = 2'($urandom);
        end
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_data = bp_d[acc_cnt]; in_mode = bp_m[acc_cnt];
            @(negedge clk);
            if (in_ready) acc_cnt++;
            tick();
        end
        check("bp_accepted", 64'(acc_cnt), 64'(ST8));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        guard = 0;
        while (acc_cnt < 4 && guard < 20) begin
            in_valid = 1'b1; in_data = bp_d[acc_cnt]; in_mode = bp_m[acc_cnt];
            @(negedge clk);
            if (in_ready) acc_cnt++;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        guard = 0;
        while (q8.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("bp_drain", 64'(q8.size()), 64'(0));

        // Reset with two beats in flight.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; in_data = 8'(rdat(8)); in_mode = 2'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        rst = 1'b1;
        q8.delete();
        q5.delete();
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'(0));
        check("rst_mid_ready", 64'(in_ready), 64'(0));
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        check("post_rst_quiet", 64'(out_valid), 64'(0));
        dir8("post_rst", 8'b0100_0000, 2'b00, 3'd1, 1'b1, 8'b1000_0000);

        // Random traffic on both instances.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom % 3) != 0;
            in_data   = 8'(rdat(8));
            in_mode   = 2'($urandom);
            out_ready = ($urandom % 4) != 0;
            v5        = ($urandom % 3) != 0;
            d5        = 5'(rdat(5));
            m5        = 2'($urandom);
            tick();
        end
        in_valid = 1'b0; v5 = 1'b0; out_ready = 1'b1;
        guard = 0;
        while ((q8.size() != 0 || q5.size() != 0) && guard < 50) begin
            tick();
            guard++;
        end
        check("drain8", 64'(q8.size()), 64'(0));
        check("drain5", 64'(q5.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
